// File: rtl/morty_pipeline_interlock.sv
// Stall/flush interlock for the 5-stage core: load-use, drain, memory wait, branch flush.
// Optional stall-cycle performance counter when MORTY_INTERLOCK_PERF_EN is defined.
module morty_pipeline_interlock #(
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hazard_i,
    input  logic [1:0]       fwd_sel_a_i,
    input  logic [1:0]       fwd_sel_b_i,
    input  logic             enable_fwd_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             ex_is_load_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    input  logic             flush_req_i,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             ex_stall_o,
    output logic             mem_stall_o,
    output logic             id_flush_o,
    output logic             ex_bubble_o,
    output logic             wb_bubble_o,
    output logic             drain_timeout_o
`ifdef MORTY_INTERLOCK_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o
`endif
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LOAD_USE = 2'd1,
        S_DRAIN    = 2'd2,
        S_MEM_WAIT = 2'd3
    } state_e;

    localparam logic [7:0] STALL_MAX_C = 8'(STALL_MAX);

    if (STALL_MAX < 4 || STALL_MAX > 255 || CNT_W == 0) begin : g_bad_cfg
        $error("morty_pipeline_interlock: illegal STALL_MAX or CNT_W");
    end

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_q, pend_d;
    logic       tout_q;

    logic lu, dr, mw, fire, pend_set;
    logic hold_fd, hold_all, flush_now, bub_ex, hit;

    assign lu = ex_is_load_i
              & ((fwd_sel_a_i == 2'b01 & id_use_rs1_i)
              |  (fwd_sel_b_i == 2'b01 & id_use_rs2_i));
    assign dr = !enable_fwd_i & hazard_i & (id_use_rs1_i | id_use_rs2_i);
    assign mw = mem_req_i & !mem_ack_i;

    // A flush seen during a memory stall is parked until the wait is over.
    assign pend_set = flush_req_i & (mw | state_q == S_MEM_WAIT);
    assign fire     = !mw & (state_q != S_MEM_WAIT) & (flush_req_i | pend_q);
    assign pend_d   = fire ? 1'b0 : (pend_q | pend_set);

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        hit       = 1'b0;
        hold_fd   = 1'b0;
        hold_all  = 1'b0;
        flush_now = 1'b0;
        bub_ex    = 1'b0;
        unique case (state_q)
            S_MEM_WAIT: begin
                if (mw) begin
                    hold_all = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_LOAD_USE: begin
                state_d = S_RUN;
                if (mw) begin
                    hold_all = 1'b1;
                    state_d  = S_MEM_WAIT;
                end else if (fire) begin
                    flush_now = 1'b1;
                    bub_ex    = 1'b1;
                end
            end
            default: begin
                state_d = S_RUN;
                if (mw) begin
                    hold_all = 1'b1;
                    state_d  = S_MEM_WAIT;
                end else if (fire) begin
                    flush_now = 1'b1;
                    bub_ex    = 1'b1;
                end else if (lu) begin
                    hold_fd = 1'b1;
                    bub_ex  = 1'b1;
                    state_d = S_LOAD_USE;
                end else if (dr) begin
                    hold_fd = 1'b1;
                    bub_ex  = 1'b1;
                    state_d = S_DRAIN;
                    if (state_q == S_DRAIN) begin
                        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    end else begin
                        cnt_d = 8'd1;
                    end
                    hit = (cnt_d == STALL_MAX_C);
                end
            end
        endcase
    end

    assign if_stall_o      = rst_ni & (hold_fd | hold_all);
    assign id_stall_o      = rst_ni & (hold_fd | hold_all);
    assign ex_stall_o      = rst_ni & hold_all;
    assign mem_stall_o     = rst_ni & hold_all;
    assign id_flush_o      = rst_ni & flush_now;
    assign ex_bubble_o     = rst_ni & bub_ex;
    assign wb_bubble_o     = rst_ni & hold_all;
    assign drain_timeout_o = rst_ni & (tout_q | hit);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            tout_q  <= tout_q | hit;
        end
    end

`ifdef MORTY_INTERLOCK_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (if_stall_o) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_morty_pipeline_interlock.sv
// Self-checking bench for morty_pipeline_interlock (vector table + scoreboard queue).
// Hand-written sequences cover async reset mid-stall and the optional perf counter.
module tb_morty_pipeline_interlock;

    localparam logic [11:0] HZ     = 12'h001;
    localparam logic [11:0] SA_EX  = 12'h002;
    localparam logic [11:0] SA_MEM = 12'h004;
    localparam logic [11:0] SB_EX  = 12'h008;
    localparam logic [11:0] EN     = 12'h020;
    localparam logic [11:0] U1     = 12'h040;
    localparam logic [11:0] U2     = 12'h080;
    localparam logic [11:0] LD     = 12'h100;
    localparam logic [11:0] RQ     = 12'h200;
    localparam logic [11:0] AK     = 12'h400;
    localparam logic [11:0] FL     = 12'h800;

    localparam logic [7:0] O_IF  = 8'h80;
    localparam logic [7:0] O_ID  = 8'h40;
    localparam logic [7:0] O_EX  = 8'h20;
    localparam logic [7:0] O_MEM = 8'h10;
    localparam logic [7:0] O_IDF = 8'h08;
    localparam logic [7:0] O_EXB = 8'h04;
    localparam logic [7:0] O_WBB = 8'h02;
    localparam logic [7:0] O_TO  = 8'h01;
    localparam logic [7:0] STL   = O_IF | O_ID | O_EXB;
    localparam logic [7:0] ALL   = O_IF | O_ID | O_EX | O_MEM | O_WBB;
    localparam logic [7:0] FLS   = O_IDF | O_EXB;
    localparam logic [7:0] NONE  = 8'h00;
    localparam logic [11:0] P    = LD | SA_EX | U1 | HZ;

    logic       clk = 1'b0;
    logic       rst_ni;
    logic       hazard, en_fwd, use1, use2, is_load;
    logic       mem_req, mem_ack, flush_req;
    logic [1:0] sel_a, sel_b;
    logic       if_st, id_st, ex_st, mem_st, id_fl, ex_bb, wb_bb, tout;
    logic [7:0] outv;
`ifdef MORTY_INTERLOCK_PERF_EN
    logic [31:0] stall_cycles;
`endif

    morty_pipeline_interlock #(
        .STALL_MAX(4),
        .CNT_W    (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .hazard_i       (hazard),
        .fwd_sel_a_i    (sel_a),
        .fwd_sel_b_i    (sel_b),
        .enable_fwd_i   (en_fwd),
        .id_use_rs1_i   (use1),
        .id_use_rs2_i   (use2),
        .ex_is_load_i   (is_load),
        .mem_req_i      (mem_req),
        .mem_ack_i      (mem_ack),
        .flush_req_i    (flush_req),
        .if_stall_o     (if_st),
        .id_stall_o     (id_st),
        .ex_stall_o     (ex_st),
        .mem_stall_o    (mem_st),
        .id_flush_o     (id_fl),
        .ex_bubble_o    (ex_bb),
        .wb_bubble_o    (wb_bb),
        .drain_timeout_o(tout)
`ifdef MORTY_INTERLOCK_PERF_EN
        ,
        .stall_cycles_o (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    assign outv = {if_st, id_st, ex_st, mem_st, id_fl, ex_bb, wb_bb, tout};

    typedef struct {
        logic [11:0] in;
        logic [7:0]  exp;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        string      nm;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic void add(input logic [11:0] in, input logic [7:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic [11:0] in);
        {flush_req, mem_ack, mem_req, is_load, use2, use1,
         en_fwd, sel_b, sel_a, hazard} = in;
    endtask

    task automatic expect_out(input logic [7:0] exp, input string nm);
        sb_t e;
        e.exp = exp;
        e.nm  = nm;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        sb_t e;
        n_run++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty: no expected value queued");
        end else begin
            e = sbq.pop_front();
            if (outv !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %b want %b (if id ex mem idf exb wbb to)",
                         e.nm, outv, e.exp);
            end
        end
    endtask

    task automatic cyc(input logic [11:0] in, input logic [7:0] exp, input string nm);
        @(posedge clk);
        #1;
        drive(in);
        expect_out(exp, nm);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        drive(EN);
        repeat (2) @(posedge clk);
        #1;
        expect_out(NONE, "reset_idle");
        check_out();
        drive(RQ | P);
        #1;
        expect_out(NONE, "reset_active_inputs");
        check_out();
        drive(EN);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        add(EN, NONE);
        add(EN | LD | SA_EX | U1, STL);
        add(EN | LD | SA_EX | U1, NONE);
        add(EN, NONE);
        add(EN | LD | SB_EX | U2, STL);
        add(EN, NONE);
        add(EN | LD | SA_MEM | U1, NONE);
        add(EN | LD | SA_EX | U2, NONE);
        add(EN | SA_EX | U1, NONE);
        for (int i = 0; i < 3; i++) add(HZ | U1, STL);
        add(EN, NONE);
        add(EN | HZ | U1, NONE);
        add(HZ, NONE);
        for (int i = 0; i < 5; i++) add(EN | RQ, ALL);
        add(EN | RQ | AK, NONE);
        add(EN, NONE);
        add(EN | RQ | AK, NONE);
        add(EN | RQ, ALL);
        add(EN | RQ | FL, ALL);
        add(EN | RQ, ALL);
        add(EN | RQ, ALL);
        add(EN | RQ | AK, NONE);
        add(EN, FLS);
        add(EN, NONE);
        add(EN | FL, FLS);
        add(EN, NONE);
        add(EN | FL | LD | SA_EX | U1, FLS);
        add(EN, NONE);
        add(RQ | P, ALL);
        add(RQ | P, ALL);
        add(RQ | AK | P, NONE);
        add(P, STL);
        add(P, NONE);
        add(HZ | U1, STL);
        add(EN, NONE);
        add(EN | RQ | FL, ALL);
        add(EN | RQ | FL, ALL);
        add(EN | RQ | AK, NONE);
        add(EN, FLS);
        add(EN, NONE);
        add(HZ | U1, STL);
        add(HZ | U1, STL);
        add(HZ | U1 | FL, FLS);
        for (int i = 0; i < 3; i++) add(HZ | U1, STL);
        add(EN, NONE);
        for (int i = 0; i < 6; i++) add(HZ | U1, (i < 3) ? STL : (STL | O_TO));
        add(EN, O_TO);
        add(EN, O_TO);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
        end

        cyc(HZ | U1, STL | O_TO, "pre_rst_drain0");
        cyc(HZ | U1, STL | O_TO, "pre_rst_drain1");
        #1;
        rst_ni = 1'b0;
        #1;
        expect_out(NONE, "rst_mid_drain");
        check_out();
        @(posedge clk);
        #1;
        drive(EN);
        rst_ni = 1'b1;
        @(negedge clk);
        expect_out(NONE, "post_rst_idle");
        check_out();
        cyc(HZ | U1, STL, "post_rst_drain");
        cyc(EN, NONE, "post_rst_exit");

        cyc(EN | RQ | FL, ALL, "pend_before_rst");
        #1;
        rst_ni = 1'b0;
        drive(EN);
        #1;
        expect_out(NONE, "rst_mid_memwait");
        check_out();
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        cyc(EN, NONE, "pend_lost0");
        cyc(EN, NONE, "pend_lost1");

`ifdef MORTY_INTERLOCK_PERF_EN
        for (int i = 0; i < 10; i++) begin
            cyc(HZ | U1, (i < 3) ? STL : (STL | O_TO), $sformatf("perf_stall%0d", i));
        end
        cyc(EN, O_TO, "perf_exit");
        n_run++;
        if (stall_cycles !== 32'd10) begin
            n_fail++;
            $display("FAIL perf_count: got %0d want 10", stall_cycles);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        n_run++;
        if (stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got %0d want 0", stall_cycles);
        end
        rst_ni = 1'b1;
`endif

        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d entries not compared", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
